// File: rtl/ckpt_free_list_if.sv
// Rename-stage free-list port bundle: allocate lanes, retire-free lanes,
// branch checkpoint control, exception flush and status.
interface ckpt_free_list_if #(
  parameter int SIZE     = 64,
  parameter int N        = 2,
  parameter int NUM_CKPT = 4
);
  localparam int PW = $clog2(SIZE);
  localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  logic [N-1:0]          pop_en;
  logic [N-1:0]          pop_valid;
  logic [N-1:0][PW-1:0]  pop_prn;
  logic [N-1:0]          push_valid;
  logic [N-1:0][PW-1:0]  push_prn;
  logic                  ckpt_en;
  logic [CW-1:0]         ckpt_id;
  logic                  restore_en;
  logic [CW-1:0]         restore_id;
  logic                  ckpt_release_en;
  logic [CW-1:0]         ckpt_release_id;
  logic                  flush_en;
  logic [PW:0]           free_count;
  logic [NUM_CKPT-1:0]   ckpt_valid;
  logic                  err;

  modport master (
    output pop_en, push_valid, push_prn, ckpt_en, ckpt_id, restore_en, restore_id,
           ckpt_release_en, ckpt_release_id, flush_en,
    input  pop_valid, pop_prn, free_count, ckpt_valid, err
  );

  modport slave (
    input  pop_en, push_valid, push_prn, ckpt_en, ckpt_id, restore_en, restore_id,
           ckpt_release_en, ckpt_release_id, flush_en,
    output pop_valid, pop_prn, free_count, ckpt_valid, err
  );
endinterface

// File: rtl/ckpt_free_list.sv
// Physical-register free list with N-wide allocate/free, head checkpoints
// for one-cycle mispredict recovery, and an exception flush that returns
// every speculative allocation. Only the head is ever rolled back.
module ckpt_free_list #(
  parameter int SIZE     = 64,
  parameter int ARCH     = 32,
  parameter int N        = 2,
  parameter int NUM_CKPT = 4
) (
  input logic            clock,
  input logic            reset,
  ckpt_free_list_if.slave fl
);
  localparam int PW = $clog2(SIZE);
  typedef logic [PW:0] ptr_t;

  logic [PW-1:0]        entries [SIZE];
  ptr_t                 head, tail;
  ptr_t                 ckpt_ptr [NUM_CKPT];
  logic [NUM_CKPT-1:0]  ckpt_vld;
  logic                 err_q;

  ptr_t                 count, n_grant, n_push, room, tail_next, head_next;
  logic [PW-1:0]        rd_idx;
  logic [N-1:0]         push_acc;
  logic [N-1:0][PW-1:0] push_idx;
  logic                 restore_ok, restore_bad, suppress, push_drop;

  assign count       = tail - head;
  assign restore_ok  = fl.restore_en && ckpt_vld[fl.restore_id];
  // A restore that loses to a flush is not an error; it simply never happened.
  assign restore_bad = fl.restore_en && !ckpt_vld[fl.restore_id] && !fl.flush_en;
  // Any restore request (good or bad) freezes the head, so no pops that cycle.
  assign suppress    = reset || fl.flush_en || fl.restore_en;

  // Grant lanes oldest-first while entries remain; granted lanes read consecutive slots.
  always_comb begin
    n_grant      = '0;
    rd_idx       = '0;
    fl.pop_valid = '0;
    fl.pop_prn   = '0;
    for (int k = 0; k < N; k++) begin
      if (!suppress && fl.pop_en[k] && (n_grant < count)) begin
        rd_idx          = head[PW-1:0] + n_grant[PW-1:0];
        fl.pop_valid[k] = 1'b1;
        fl.pop_prn[k]   = entries[rd_idx];
        n_grant         = n_grant + ptr_t'(1);
      end
    end
  end

  // Accept pushes in lane order until the list would overflow; this cycle's pops free room.
  always_comb begin
    room      = ptr_t'(SIZE) - (count - n_grant);
    n_push    = '0;
    push_acc  = '0;
    push_idx  = '0;
    push_drop = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (fl.push_valid[k]) begin
        if (n_push < room) begin
          push_acc[k] = 1'b1;
          push_idx[k] = tail[PW-1:0] + n_push[PW-1:0];
          n_push      = n_push + ptr_t'(1);
        end else begin
          push_drop = 1'b1;
        end
      end
    end
    tail_next = tail + n_push;
  end

  // Head selection: flush rebuilds from the new tail, restore reloads a checkpoint.
  always_comb begin
    head_next = head + n_grant;
    if (fl.flush_en)      head_next = tail_next - ptr_t'(SIZE - ARCH);
    else if (restore_ok)  head_next = ckpt_ptr[fl.restore_id];
  end

  // Pointer, storage, checkpoint and error state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) entries[i] <= PW'(i);
      for (int i = 0; i < NUM_CKPT; i++) ckpt_ptr[i] <= '0;
      head     <= ptr_t'(ARCH);
      tail     <= {1'b1, {PW{1'b0}}};
      ckpt_vld <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++)
        if (push_acc[k]) entries[push_idx[k]] <= fl.push_prn[k];
      head <= head_next;
      tail <= tail_next;
      if (push_drop || restore_bad) err_q <= 1'b1;
      if (fl.flush_en || restore_ok) begin
        ckpt_vld <= '0;
      end else begin
        if (fl.ckpt_release_en) ckpt_vld[fl.ckpt_release_id] <= 1'b0;
        // Later assignment lets a same-slot checkpoint beat the release.
        if (fl.ckpt_en && !fl.restore_en) begin
          ckpt_vld[fl.ckpt_id] <= 1'b1;
          ckpt_ptr[fl.ckpt_id] <= head + n_grant;
        end
      end
    end
  end

  assign fl.free_count = count;
  assign fl.ckpt_valid = ckpt_vld;
  assign fl.err        = err_q;
endmodule

// File: tb/tb_ckpt_free_list.sv
// Bench for ckpt_free_list: directed table, hand sequences for fill/drain,
// overflow and pointer wrap, then legal random traffic against a queue model.
module tb_ckpt_free_list;
  localparam int SIZE = 64, ARCH = 32, N = 2, NUM_CKPT = 4, PW = 6;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ckpt_free_list_if #(.SIZE(SIZE), .N(N), .NUM_CKPT(NUM_CKPT)) fl();
  ckpt_free_list #(.SIZE(SIZE), .ARCH(ARCH), .N(N), .NUM_CKPT(NUM_CKPT))
    dut (.clock(clock), .reset(reset), .fl(fl.slave));

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] pop;  logic [1:0] pv;  logic [5:0] p0;  logic [5:0] p1;
    logic ck; logic [1:0] cid; logic rs; logic [1:0] rid;
    logic rl; logic [1:0] rlid; logic fls;
    logic [1:0] e_pv; logic [5:0] e_p0; logic [5:0] e_p1;
    logic [6:0] e_fc; logic [3:0] e_cv; logic e_err;
  } vec_t;
  vec_t tab [14];

  // reference model: free queue, speculative allocations, committed mappings
  int fq[$], spec[$], comm[$], q[$];
  int spec_base;
  int cseq [NUM_CKPT];
  logic [NUM_CKPT-1:0] cval;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] pop, input logic [1:0] pv, input logic [5:0] p0,
                       input logic [5:0] p1, input logic ck, input logic [1:0] cid,
                       input logic rs, input logic [1:0] rid, input logic rl,
                       input logic [1:0] rlid, input logic fls);
    fl.pop_en = pop; fl.push_valid = pv; fl.push_prn[0] = p0; fl.push_prn[1] = p1;
    fl.ckpt_en = ck; fl.ckpt_id = cid; fl.restore_en = rs; fl.restore_id = rid;
    fl.ckpt_release_en = rl; fl.ckpt_release_id = rlid; fl.flush_en = fls;
  endtask

  task automatic step_chk(input string tag, input logic [1:0] e_pv, input logic [5:0] e_p0,
                          input logic [5:0] e_p1, input logic [6:0] e_fc,
                          input logic [3:0] e_cv, input logic e_err);
    @(negedge clock);
    chk({tag, ".pop_valid"}, 32'(fl.pop_valid), 32'(e_pv));
    chk({tag, ".prn0"}, 32'(fl.pop_prn[0]), 32'(e_p0));
    chk({tag, ".prn1"}, 32'(fl.pop_prn[1]), 32'(e_p1));
    chk({tag, ".free_count"}, 32'(fl.free_count), 32'(e_fc));
    chk({tag, ".ckpt_valid"}, 32'(fl.ckpt_valid), 32'(e_cv));
    chk({tag, ".err"}, 32'(fl.err), 32'(e_err));
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("reset.pop_valid", 32'(fl.pop_valid), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    fq.delete(); spec.delete(); comm.delete();
    for (int i = ARCH; i < SIZE; i++) fq.push_back(i);
    for (int i = 0; i < ARCH; i++) comm.push_back(i);
    spec_base = 0;
    cval = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] pe, pv, e_pv;
    logic [5:0] pp0, pp1, e_p0, e_p1, prev0, prev1;
    logic fl_e, rs_e, ck_e, rl_e;
    int rid, cid, rlid, nret, ng, r, min_ck;
    bit have_prev;

    // ---------------- directed table: checkpoint, restore, flush, release
    tab[0]  = '{pop:2'b11, e_pv:2'b11, e_p0:6'd32, e_p1:6'd33, e_fc:7'd32, default:'0};
    tab[1]  = '{pop:2'b11, ck:1'b1, cid:2'd1, e_pv:2'b11, e_p0:6'd34, e_p1:6'd35, e_fc:7'd30, default:'0};
    tab[2]  = '{pop:2'b11, e_pv:2'b11, e_p0:6'd36, e_p1:6'd37, e_fc:7'd28, e_cv:4'b0010, default:'0};
    tab[3]  = '{pop:2'b11, e_pv:2'b11, e_p0:6'd38, e_p1:6'd39, e_fc:7'd26, e_cv:4'b0010, default:'0};
    tab[4]  = '{pop:2'b11, rs:1'b1, rid:2'd1, e_fc:7'd24, e_cv:4'b0010, default:'0};
    tab[5]  = '{pop:2'b11, e_pv:2'b11, e_p0:6'd36, e_p1:6'd37, e_fc:7'd28, default:'0};
    tab[6]  = '{rs:1'b1, rid:2'd1, e_fc:7'd26, default:'0};
    tab[7]  = '{e_fc:7'd26, e_err:1'b1, default:'0};
    tab[8]  = '{pop:2'b11, pv:2'b11, p0:6'd0, p1:6'd1, fls:1'b1, e_fc:7'd26, e_err:1'b1, default:'0};
    tab[9]  = '{pop:2'b01, e_pv:2'b01, e_p0:6'd34, e_fc:7'd32, e_err:1'b1, default:'0};
    tab[10] = '{ck:1'b1, cid:2'd2, e_fc:7'd31, e_err:1'b1, default:'0};
    tab[11] = '{ck:1'b1, cid:2'd2, rl:1'b1, rlid:2'd2, e_fc:7'd31, e_cv:4'b0100, e_err:1'b1, default:'0};
    tab[12] = '{rl:1'b1, rlid:2'd2, e_fc:7'd31, e_cv:4'b0100, e_err:1'b1, default:'0};
    tab[13] = '{e_fc:7'd31, e_err:1'b1, default:'0};

    do_reset();
    step_chk("after_reset", 2'b00, 0, 0, 7'd32, 4'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      drive(tab[i].pop, tab[i].pv, tab[i].p0, tab[i].p1, tab[i].ck, tab[i].cid,
            tab[i].rs, tab[i].rid, tab[i].rl, tab[i].rlid, tab[i].fls);
      step_chk($sformatf("tab%0d", i), tab[i].e_pv, tab[i].e_p0, tab[i].e_p1,
               tab[i].e_fc, tab[i].e_cv, tab[i].e_err);
    end

    // ---------------- drain to empty, partial grant, no push bypass
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step_chk($sformatf("drain%0d", i), 2'b11, 6'(32 + 2*i), 6'(33 + 2*i), 7'(32 - 2*i), 0, 0);
    end
    drive(2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_chk("drain_last2", 2'b01, 6'd62, 0, 7'd2, 0, 0);
    drive(2'b11, 2'b01, 6'd5, 0, 0, 0, 0, 0, 0, 0, 0);
    step_chk("partial_grant", 2'b01, 6'd63, 0, 7'd1, 0, 0);
    drive(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_chk("pushed_prn", 2'b01, 6'd5, 0, 7'd1, 0, 0);
    step_chk("empty", 2'b00, 0, 0, 7'd0, 0, 0);

    // ---------------- fill to full, overflow push, then wrap the pointers
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(0, 2'b11, 6'(2*i), 6'(2*i + 1), 0, 0, 0, 0, 0, 0, 0);
      step_chk($sformatf("fill%0d", i), 0, 0, 0, 7'(32 + 2*i), 0, 0);
    end
    drive(0, 2'b01, 6'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    step_chk("overflow_push", 0, 0, 0, 7'd64, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_chk("overflow_dropped", 0, 0, 0, 7'd64, 0, 1'b1);
    q.delete();
    for (int i = 32; i < 64; i++) q.push_back(i);
    for (int i = 0; i < 32; i++) q.push_back(i);
    have_prev = 1'b0; prev0 = 0; prev1 = 0;
    for (int j = 0; j < 40; j++) begin
      drive(2'b11, have_prev ? 2'b11 : 2'b00, prev0, prev1, 0, 0, 0, 0, 0, 0, 0);
      step_chk($sformatf("wrap%0d", j), 2'b11, 6'(q[0]), 6'(q[1]), 7'(q.size()), 0, 1'b1);
      pp0 = 6'(q.pop_front());
      pp1 = 6'(q.pop_front());
      if (have_prev) begin q.push_back(int'(prev0)); q.push_back(int'(prev1)); end
      prev0 = pp0; prev1 = pp1; have_prev = 1'b1;
    end

    // ---------------- legal random traffic against the queue model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      fl_e = ($urandom_range(19) == 0);
      rid  = $urandom_range(NUM_CKPT - 1);
      rs_e = !fl_e && ($urandom_range(7) == 0) && cval[rid];
      ck_e = ($urandom_range(3) == 0);
      cid  = $urandom_range(NUM_CKPT - 1);
      rl_e = ($urandom_range(3) == 0);
      rlid = $urandom_range(NUM_CKPT - 1);
      pe   = 2'($urandom_range(3));
      // retire may not pass an unresolved branch
      min_ck = 1 << 30;
      for (int i = 0; i < NUM_CKPT; i++) if (cval[i] && cseq[i] < min_ck) min_ck = cseq[i];
      nret = 0; pv = 0; pp0 = 0; pp1 = 0;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(1) == 1 && nret < spec.size() && spec_base + nret < min_ck) begin
          pv[k] = 1'b1;
          if (k == 0) pp0 = 6'(comm[nret]); else pp1 = 6'(comm[nret]);
          nret++;
        end
      end
      drive(pe, pv, pp0, pp1, ck_e, 2'(cid), rs_e, 2'(rid), rl_e, 2'(rlid), fl_e);
      e_pv = 0; e_p0 = 0; e_p1 = 0; ng = 0;
      if (!fl_e && !rs_e) begin
        for (int k = 0; k < N; k++) begin
          if (pe[k] && ng < fq.size()) begin
            e_pv[k] = 1'b1;
            if (k == 0) e_p0 = 6'(fq[ng]); else e_p1 = 6'(fq[ng]);
            ng++;
          end
        end
      end
      step_chk("rnd", e_pv, e_p0, e_p1, 7'(fq.size()), cval, 1'b0);
      repeat (ng) spec.push_back(fq.pop_front());
      repeat (nret) begin
        fq.push_back(comm.pop_front());
        comm.push_back(spec.pop_front());
        spec_base++;
      end
      if (rl_e) cval[rlid] = 1'b0;
      if (ck_e && !fl_e && !rs_e) begin
        cseq[cid] = spec_base + spec.size();
        cval[cid] = 1'b1;
      end
      if (rs_e) begin
        r = spec_base + spec.size() - cseq[rid];
        repeat (r) fq.push_front(spec.pop_back());
        cval = '0;
      end
      if (fl_e) begin
        while (spec.size() > 0) fq.push_front(spec.pop_back());
        cval = '0;
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_chk("rnd_final", 0, 0, 0, 7'(fq.size()), cval, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ckpt_free_list.md
Name: ckpt_free_list

Overview:
- Parametrised physical-register free list for the rename stage, N-wide allocate and N-wide free per cycle.
- Adds NUM_CKPT branch checkpoints of the head pointer, so a mispredict restores in one cycle with no external state copy.
- Adds an exception flush that returns every speculative allocation to the list.
- Retire-side frees are non-speculative and are never rolled back; only the head is checkpointed.

Parameters:
SIZE, 64, number of physical registers and list depth; power of two.
ARCH, 32, architectural registers; at reset PRNs 0..ARCH-1 are mapped and not free.
N, 2, pop lanes and push lanes per cycle.
NUM_CKPT, 4, number of head checkpoints.
Derived: PW = $clog2(SIZE) for PRN and index width; pointers are PW+1 bits, with the MSB as the wrap bit.

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
pop_en  in  N  allocation request per lane; lane 0 is oldest
pop_valid  out  N  lane granted
pop_prn  out  N*PW  granted PRN per lane; 0 when not granted
push_valid  in  N  free request per lane (retire)
push_prn  in  N*PW  PRN to free
ckpt_en  in  1  save a checkpoint this cycle
ckpt_id  in  $clog2(NUM_CKPT)  checkpoint slot to write
restore_en  in  1  mispredict: restore head from checkpoint
restore_id  in  $clog2(NUM_CKPT)  checkpoint slot to read
ckpt_release_en  in  1  branch resolved correct: invalidate slot
ckpt_release_id  in  $clog2(NUM_CKPT)  slot to invalidate
flush_en  in  1  exception: free all speculative allocations
free_count  out  PW+1  entries currently free (registered)
ckpt_valid  out  NUM_CKPT  slot-valid vector
err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Storage: circular array entries[SIZE], head and tail pointers, each PW+1 bits; free_count = tail - head (mod 2^(PW+1)).
- Reset: entries[i] = i; head = {0, ARCH}; tail = {1, 0}; free_count = SIZE-ARCH; ckpt_valid = 0; err = 0; pop outputs 0.
- Pop (combinational, same cycle):
  - Lanes are scanned 0..N-1; a requesting lane is granted while entries remain after earlier grants. Partial grants are allowed.
  - Granted lane k reads entries[(head + grant index) mod SIZE].
  - head advances by the number of grants at the clock edge.
- Push (takes effect at the clock edge):
  - Valid lanes are written in lane order at tail, tail+1, ... and tail advances by the number of accepted pushes.
  - A PRN pushed in cycle t is poppable from cycle t+1; there is no bypass.
  - A push that would make free_count exceed SIZE is dropped and sets err.
  - Pushes are applied in every cycle, including restore and flush cycles.
- Checkpoint:
  - On ckpt_en, slot[ckpt_id] is loaded with head after this cycle's pops, and its valid bit is set.
  - Allocations in the same cycle as a branch are therefore treated as older than the branch.
  - Overwriting a valid slot is legal.
- Restore (restore_en and slot valid):
  - head <= slot[restore_id]; this cycle's pops are suppressed (all pop_valid = 0).
  - restore_id and every other slot are invalidated. All slots are cleared because the rename stage allocates checkpoint slots in order and squashes all younger branches.
  - A same-cycle ckpt_en is ignored.
  - restore_en to an invalid slot: no state change and err set.
- Release: on ckpt_release_en, ckpt_valid[ckpt_release_id] <= 0. If it coincides with ckpt_en to the same id, ckpt_en wins.
- Flush:
  - head <= tail_next - (SIZE-ARCH), where tail_next includes this cycle's pushes, so free_count = SIZE-ARCH.
  - Pops are suppressed and all ckpt_valid bits are cleared.
  - Flush has priority over restore and ckpt_en.
- Priority per cycle: flush > restore > normal pop and checkpoint. Push and release are always applied.
- Wrap-around is handled by the PW+1-bit pointer arithmetic; indices use the low PW bits.
- free_count is never negative, because pops are bounded by the current count.
- Reset asserted mid-operation overrides all inputs in that cycle.

Test Plan:
- Reset, then pop_en=2'b11 each cycle for 16 cycles -> PRNs 32,33,...,63 granted in order; cycle 17 gives pop_valid=00; free_count reaches 0.
- With free_count=1, pop_en=11 -> lane0 valid with PRN 63 and lane1 not valid. Next cycle, push 5 -> pop gives PRN 5 (no same-cycle bypass).
- Reset, pop 2, ckpt_en id=1 together with pop 2, pop 4 more, then restore_en id=1 -> free_count=28; next pop yields 36,37; ckpt_valid=0.
- With the list full (free_count=64 after pushes), a further push_valid=01 -> entry dropped, err=1, free_count stays 64.
- Mid-run, flush_en with 2 pushes in the same cycle -> free_count=32 next cycle; ckpt_valid=0; pop_valid=0 that cycle.
- restore_en to an invalid slot -> head unchanged, err=1. Drive 40 pop/push cycles so the pointers wrap past index 63 -> PRN order is preserved and free_count stays consistent.
